// File: rtl/equiv_stim_gen.sv
// ---------------------------------------------------------------------------
// equiv_stim_gen
//
// Stimulus source for the equivalence-checking harness. A 64-bit Galois LFSR
// produces a bounded run of pseudo-random vectors which are sliced onto the
// shared input bus (wire0..wire3) that feeds both copies of the design under
// comparison. The downstream miter consumes these vectors.
//
// Parameters
//   SEED    reset / fallback LFSR value (must be non-zero)
//   CYCLES  vectors emitted per run, 1..65535
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   begin a run (honoured in IDLE and DONE)
//   seed_load  in   capture seed into the seed register (IDLE and DONE)
//   seed       in   64-bit seed value (zero is replaced by SEED)
//   hold       in   freeze LFSR, counter and outputs while running
//   wire0      out  13-bit unsigned slice  lfsr[12:0]
//   wire1      out  18-bit signed slice    lfsr[30:13]
//   wire2      out  21-bit unsigned slice  lfsr[51:31]
//   wire3      out  5-bit signed slice     lfsr[56:52]
//   busy       out  high while a run is in progress
//   done       out  high once a run has completed
//   vec_cnt    out  vectors emitted in the current or last run
// ---------------------------------------------------------------------------
module equiv_stim_gen #(
    parameter logic [63:0] SEED   = 64'h0000_0000_0000_0001,
    parameter logic [15:0] CYCLES = 16'd1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               seed_load,
    input  logic [63:0]        seed,
    input  logic               hold,
    output logic [12:0]        wire0,
    output logic signed [17:0] wire1,
    output logic [20:0]        wire2,
    output logic signed [4:0]  wire3,
    output logic               busy,
    output logic               done,
    output logic [15:0]        vec_cnt
);

    // Feedback taps for x^64+x^63+x^61+x^60+1 in right-shifting Galois form.
    localparam logic [63:0] POLY = 64'hD800_0000_0000_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [63:0]        r_seed;
    logic [63:0]        r_lfsr;
    logic [15:0]        r_vec_cnt;
    logic [12:0]        r_wire0;
    logic signed [17:0] r_wire1;
    logic [20:0]        r_wire2;
    logic signed [4:0]  r_wire3;
    logic               r_busy;
    logic               r_done;

    logic [63:0]        w_lfsr_next;
    logic [63:0]        w_seed_fix;
    logic               w_last;

    assign w_lfsr_next = (r_lfsr >> 1) ^ (r_lfsr[0] ? POLY : 64'h0);

    // A zero seed would lock the LFSR at zero forever, so substitute SEED.
    assign w_seed_fix  = (seed == 64'h0) ? SEED : seed;

    // True on the advance cycle that emits the final vector of the run.
    assign w_last      = (r_vec_cnt == (CYCLES - 16'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_seed    <= SEED;
            r_lfsr    <= SEED;
            r_vec_cnt <= 16'd0;
            r_wire0   <= '0;
            r_wire1   <= '0;
            r_wire2   <= '0;
            r_wire3   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    // Outputs, lfsr and vec_cnt keep their values here.
                    if (seed_load) begin
                        r_seed <= w_seed_fix;
                    end
                    if (start) begin
                        // A seed presented together with start takes effect
                        // for this run, bypassing the seed register.
                        r_lfsr    <= seed_load ? w_seed_fix : r_seed;
                        r_vec_cnt <= 16'd0;
                        r_state   <= S_RUN;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                    end
                end

                S_RUN: begin
                    // A held edge leaves every register untouched.
                    if (!hold) begin
                        r_wire0   <= r_lfsr[12:0];
                        r_wire1   <= $signed(r_lfsr[30:13]);
                        r_wire2   <= r_lfsr[51:31];
                        r_wire3   <= $signed(r_lfsr[56:52]);
                        r_lfsr    <= w_lfsr_next;
                        r_vec_cnt <= r_vec_cnt + 16'd1;
                        if (w_last) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign wire0   = r_wire0;
    assign wire1   = r_wire1;
    assign wire2   = r_wire2;
    assign wire3   = r_wire3;
    assign busy    = r_busy;
    assign done    = r_done;
    assign vec_cnt = r_vec_cnt;

endmodule

// File: tb/tb_equiv_stim_gen.sv
// ---------------------------------------------------------------------------
// tb_equiv_stim_gen
//
// Two generators share one stimulus: instance A runs 4 vectors per run,
// instance B runs 20. A behavioural model tracks, per instance, the seed
// register, the generator value, the last emitted vector and the run
// progress, and every sampled cycle is compared against it. Directed
// constant checks cover the known vectors of the default and DEADBEEF seeds.
// ---------------------------------------------------------------------------
module tb_equiv_stim_gen;

    localparam logic [63:0] TB_SEED = 64'h0000_0000_0000_0001;
    localparam logic [63:0] TAPS    = 64'hD800_0000_0000_0000;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        seed_load;
    logic [63:0] seed;
    logic        hold;

    logic [12:0]        a_wire0, b_wire0;
    logic signed [17:0] a_wire1, b_wire1;
    logic [20:0]        a_wire2, b_wire2;
    logic signed [4:0]  a_wire3, b_wire3;
    logic               a_busy, b_busy, a_done, b_done;
    logic [15:0]        a_vec_cnt, b_vec_cnt;

    equiv_stim_gen #(.SEED(TB_SEED), .CYCLES(16'd4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .seed_load(seed_load),
        .seed(seed), .hold(hold),
        .wire0(a_wire0), .wire1(a_wire1), .wire2(a_wire2), .wire3(a_wire3),
        .busy(a_busy), .done(a_done), .vec_cnt(a_vec_cnt)
    );

    equiv_stim_gen #(.SEED(TB_SEED), .CYCLES(16'd20)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .seed_load(seed_load),
        .seed(seed), .hold(hold),
        .wire0(b_wire0), .wire1(b_wire1), .wire2(b_wire2), .wire3(b_wire3),
        .busy(b_busy), .done(b_done), .vec_cnt(b_vec_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state, index 0 = instance A, 1 = instance B.
    int          m_len  [2] = '{4, 20};
    logic [63:0] m_seedr[2];
    logic [63:0] m_gen  [2];
    logic [63:0] m_vec  [2];
    int          m_cnt  [2];
    bit          m_run  [2];
    bit          m_fin  [2];

    function automatic logic [63:0] lfsr_adv(input logic [63:0] v);
        return (v >> 1) ^ (v[0] ? TAPS : 64'h0);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_seedr[i] = TB_SEED;
            m_gen[i]   = TB_SEED;
            m_vec[i]   = 64'h0;
            m_cnt[i]   = 0;
            m_run[i]   = 1'b0;
            m_fin[i]   = 1'b0;
        end
    endtask

    // Apply the effect of the coming clock edge using the current inputs.
    task automatic model_edge();
        logic [63:0] fixed;
        fixed = (seed == 64'h0) ? TB_SEED : seed;
        for (int i = 0; i < 2; i++) begin
            if (!m_run[i]) begin
                if (start) begin
                    m_gen[i] = seed_load ? fixed : m_seedr[i];
                    m_cnt[i] = 0;
                    m_run[i] = 1'b1;
                    m_fin[i] = 1'b0;
                end
                if (seed_load) m_seedr[i] = fixed;
            end else if (!hold) begin
                m_vec[i] = m_gen[i];
                m_gen[i] = lfsr_adv(m_gen[i]);
                m_cnt[i] = m_cnt[i] + 1;
                if (m_cnt[i] == m_len[i]) begin
                    m_run[i] = 1'b0;
                    m_fin[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("a.wire0",   {51'b0, a_wire0},   {51'b0, m_vec[0][12:0]});
        chk("a.wire1",   {46'b0, a_wire1},   {46'b0, m_vec[0][30:13]});
        chk("a.wire2",   {43'b0, a_wire2},   {43'b0, m_vec[0][51:31]});
        chk("a.wire3",   {59'b0, a_wire3},   {59'b0, m_vec[0][56:52]});
        chk("a.busy",    {63'b0, a_busy},    {63'b0, m_run[0]});
        chk("a.done",    {63'b0, a_done},    {63'b0, m_fin[0]});
        chk("a.vec_cnt", {48'b0, a_vec_cnt}, 64'(m_cnt[0]));
        chk("b.wire0",   {51'b0, b_wire0},   {51'b0, m_vec[1][12:0]});
        chk("b.wire1",   {46'b0, b_wire1},   {46'b0, m_vec[1][30:13]});
        chk("b.wire2",   {43'b0, b_wire2},   {43'b0, m_vec[1][51:31]});
        chk("b.wire3",   {59'b0, b_wire3},   {59'b0, m_vec[1][56:52]});
        chk("b.busy",    {63'b0, b_busy},    {63'b0, m_run[1]});
        chk("b.done",    {63'b0, b_done},    {63'b0, m_fin[1]});
        chk("b.vec_cnt", {48'b0, b_vec_cnt}, 64'(m_cnt[1]));
        chk("a.busy_done_excl", {63'b0, a_busy & a_done}, 64'h0);
        chk("b.busy_done_excl", {63'b0, b_busy & b_done}, 64'h0);
    endtask

    // One clock: model the edge, let it happen, sample 1 ns later.
    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while ((a_busy === 1'b1 || b_busy === 1'b1) && k < budget) begin
            cycle();
            k++;
        end
        chk("wait_idle", {62'b0, a_busy, b_busy}, 64'h0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        seed_load = 1'b0;
        seed      = 64'h0;
        hold      = 1'b0;
        model_reset();
        #3;
        compare_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Default seed run.
        start = 1'b1;
        cycle();
        start = 1'b0;
        chk("dflt.busy_after_start", {63'b0, a_busy}, 64'h1);
        cycle();
        chk("dflt.v1.wire0", {51'b0, a_wire0}, 64'h1);
        chk("dflt.v1.rest",  {a_wire1, a_wire2, a_wire3}, 64'h0);
        cycle();
        chk("dflt.v2.all", {a_wire0, a_wire1, a_wire2, a_wire3}, 64'h0);
        cycle();
        chk("dflt.done_not_yet", {63'b0, a_done}, 64'h0);
        cycle();
        chk("dflt.done", {63'b0, a_done}, 64'h1);
        chk("dflt.vec_cnt", {48'b0, a_vec_cnt}, 64'h4);
        wait_idle(40);

        // Zero seed falls back to SEED; then hold after vector 2.
        seed_load = 1'b1;
        seed      = 64'h0;
        cycle();
        seed_load = 1'b0;
        start     = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        chk("zero.v1.wire0", {51'b0, a_wire0}, 64'h1);
        cycle();
        chk("zero.v2.wire0", {51'b0, a_wire0}, 64'h0);
        hold = 1'b1;
        for (int h = 0; h < 3; h++) begin
            cycle();
            chk("hold.vec_cnt", {48'b0, a_vec_cnt}, 64'h2);
            chk("hold.done",    {63'b0, a_done},    64'h0);
        end
        hold = 1'b0;
        cycle();
        chk("hold.done_late", {63'b0, a_done}, 64'h0);
        cycle();
        chk("hold.done_delayed", {63'b0, a_done},    64'h1);
        chk("hold.vec_cnt_end",  {48'b0, a_vec_cnt}, 64'h4);
        wait_idle(40);

        // Restart from DONE with seed_load and start together.
        seed_load = 1'b1;
        start     = 1'b1;
        seed      = 64'hDEAD_BEEF_0123_4567;
        cycle();
        seed_load = 1'b0;
        start     = 1'b0;
        chk("restart.busy", {62'b0, a_busy, b_busy}, 64'h3);
        chk("restart.done", {62'b0, a_done, b_done}, 64'h0);
        cycle();
        chk("restart.v1.wire0", {51'b0, a_wire0}, 64'h0567);
        chk("restart.v1.wire3", {59'b0, a_wire3}, 64'h0A);
        cycle();

        // start/seed_load during RUN must be ignored.
        start     = 1'b1;
        seed_load = 1'b1;
        seed      = {$urandom, $urandom};
        cycle();
        start     = 1'b0;
        seed_load = 1'b0;
        chk("ignore.vec_cnt", {48'b0, a_vec_cnt}, 64'h3);
        cycle();
        chk("ignore.done",    {63'b0, a_done},    64'h1);
        chk("ignore.vec_cnt_end", {48'b0, a_vec_cnt}, 64'h4);
        wait_idle(40);

        // Randomised control traffic.
        for (int r = 0; r < 400; r++) begin
            start     = ($urandom_range(0, 9) == 0);
            seed_load = ($urandom_range(0, 7) == 0);
            hold      = ($urandom_range(0, 3) == 0);
            seed      = ($urandom_range(0, 5) == 0) ? 64'h0 : {$urandom, $urandom};
            cycle();
        end
        start     = 1'b0;
        seed_load = 1'b0;
        hold      = 1'b0;
        wait_idle(40);

        // Asynchronous reset in the middle of a run.
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int k = 0; k < 30 && b_vec_cnt !== 16'd7; k++) cycle();
        chk("rst.reach7", {48'b0, b_vec_cnt}, 64'h7);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        chk("rst.async_b", {b_wire0, b_vec_cnt, b_busy, b_done}, 64'h0);
        @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;
        start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        chk("rst.next_v1.wire0",   {51'b0, b_wire0},   64'h1);
        chk("rst.next_v1.vec_cnt", {48'b0, b_vec_cnt}, 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
